// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in parallel-out loader.
// Holds the FSM state encoding and the default word width.
package sipo_pkg;

    localparam int SIPO_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_loader_bit_counter.sv
// Bit counter for the SIPO loader: counts accepted serial bits.
// tc flags that the next accepted bit completes the word.
module bit_counter #(
    parameter int N = 8
) (
    input  logic CLK,
    input  logic N_RESET,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable; the count saturates at N.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge N_RESET) begin
        if (N_RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sipo_loader.sv
// Serial-in parallel-out loader: assembles MSB-first words and
// strobes LOAD so a downstream PIPO register takes whole words only.
module sipo_loader #(
    parameter int N = sipo_pkg::SIPO_N
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         START,
    input  logic         SER_IN,
    input  logic         SER_VALID,
    input  logic         CLR_ERR,
    output logic [N-1:0] DOUT,
    output logic         LOAD,
    output logic         BUSY,
    output logic         OVERRUN
);

    sipo_pkg::state_t state_q;
    sipo_pkg::state_t state_d;

    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;
    logic [N-1:0] dout_q;
    logic [N-1:0] dout_d;
    logic         load_q;
    logic         load_d;
    logic         busy_q;
    logic         busy_d;
    logic         overrun_q;
    logic         overrun_d;

    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;
    logic [N-1:0] shift_nxt;

    assign shift_nxt = {shreg_q[N-2:0], SER_IN};

    bit_counter #(
        .N(N)
    ) u_cnt (
        .CLK    (CLK),
        .N_RESET(N_RESET),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc     (cnt_tc)
    );

    // Next-state, datapath and sticky-error logic; outputs follow next state.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        overrun_d = overrun_q & ~CLR_ERR;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            sipo_pkg::IDLE: begin
                if (START) begin
                    state_d = sipo_pkg::SHIFT;
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            sipo_pkg::SHIFT: begin
                if (START) begin
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                end else if (SER_VALID) begin
                    shreg_d = shift_nxt;
                    cnt_en  = 1'b1;
                    if (cnt_tc) begin
                        state_d = sipo_pkg::LOAD;
                        dout_d  = shift_nxt;
                    end
                end
            end
            sipo_pkg::LOAD: begin
                cnt_clr = 1'b1;
                if (SER_VALID) begin
                    overrun_d = 1'b1;
                end
                if (START) begin
                    state_d = sipo_pkg::SHIFT;
                    shreg_d = '0;
                end else begin
                    state_d = sipo_pkg::IDLE;
                end
            end
            default: begin
                state_d = sipo_pkg::IDLE;
            end
        endcase
        load_d = (state_d == sipo_pkg::LOAD);
        busy_d = (state_d == sipo_pkg::SHIFT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or posedge N_RESET) begin
        if (N_RESET) begin
            state_q   <= sipo_pkg::IDLE;
            shreg_q   <= '0;
            dout_q    <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign DOUT    = dout_q;
    assign LOAD    = load_q;
    assign BUSY    = busy_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_sipo_loader.sv
// Self-checking bench for sipo_loader: table-driven basic word,
// hand sequences for corner cases, scoreboard on every LOAD pulse.
module tb_sipo_loader;

    logic       CLK = 1'b0;
    logic       N_RESET = 1'b1;
    logic       START = 1'b0;
    logic       SER_IN = 1'b0;
    logic       SER_VALID = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [7:0] DOUT;
    logic       LOAD;
    logic       BUSY;
    logic       OVERRUN;

    int checks = 0;
    int errors = 0;
    int loads  = 0;
    int pushed = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       s;
        logic       d;
        logic       v;
        logic       c;
        logic       e_load;
        logic       e_busy;
        logic       e_ovr;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[10];

    sipo_loader #(.N(8)) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .START    (START),
        .SER_IN   (SER_IN),
        .SER_VALID(SER_VALID),
        .CLR_ERR  (CLR_ERR),
        .DOUT     (DOUT),
        .LOAD     (LOAD),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic v,
                         input logic c);
        START = s;
        SER_IN = d;
        SER_VALID = v;
        CLR_ERR = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                sb.push_back(w);
                pushed++;
            end
            drive(1'b0, w[i], 1'b1, 1'b0);
            if (i != 0) begin
                check("busy_bit", BUSY, 1);
                check("noload_bit", LOAD, 0);
                if (gap) begin
                    drive(1'b0, ~w[i], 1'b0, 1'b0);
                    check("busy_gap", BUSY, 1);
                    check("noload_gap", LOAD, 0);
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        if (LOAD) begin
            loads++;
            if (sb.size() == 0) begin
                check("sb_unexpected_load", 1, 0);
            end else begin
                check("sb_dout", DOUT, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int l0;
        tbl[0] = '{1, 0, 0, 0, 0, 1, 0, 8'h00};
        tbl[1] = '{0, 1, 1, 0, 0, 1, 0, 8'h00};
        tbl[2] = '{0, 1, 1, 0, 0, 1, 0, 8'h00};
        tbl[3] = '{0, 0, 1, 0, 0, 1, 0, 8'h00};
        tbl[4] = '{0, 0, 1, 0, 0, 1, 0, 8'h00};
        tbl[5] = '{0, 1, 1, 0, 0, 1, 0, 8'h00};
        tbl[6] = '{0, 0, 1, 0, 0, 1, 0, 8'h00};
        tbl[7] = '{0, 1, 1, 0, 0, 1, 0, 8'h00};
        tbl[8] = '{0, 0, 1, 0, 1, 0, 0, 8'hCA};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 8'hCA};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_dout", DOUT, 0);
        check("rst_load", LOAD, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ovr", OVERRUN, 0);
        N_RESET = 1'b0;
        drive(0, 1, 1, 0);
        check("idle_ignore_busy", BUSY, 0);
        check("idle_ignore_ovr", OVERRUN, 0);

        sb.push_back(8'hCA);
        pushed++;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].s, tbl[i].d, tbl[i].v, tbl[i].c);
            check($sformatf("tbl%0d_load", i), LOAD, tbl[i].e_load);
            check($sformatf("tbl%0d_busy", i), BUSY, tbl[i].e_busy);
            check($sformatf("tbl%0d_ovr", i), OVERRUN, tbl[i].e_ovr);
            check($sformatf("tbl%0d_dout", i), DOUT, tbl[i].e_dout);
        end

        drive(1, 0, 0, 0);
        send_bits(8'hCA, 1'b1);
        check("gap_load", LOAD, 1);
        check("gap_dout", DOUT, 8'hCA);
        drive(0, 0, 0, 0);

        l0 = loads;
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 1, 0);
        check("abort_nodout", DOUT, 8'hCA);
        drive(1, 1, 1, 0);
        check("abort_busy", BUSY, 1);
        check("abort_noload", LOAD, 0);
        send_bits(8'h35, 1'b0);
        check("abort_load", LOAD, 1);
        check("abort_dout", DOUT, 8'h35);
        drive(0, 0, 0, 0);
        check("abort_one_load", loads - l0, 1);
        check("abort_ovr", OVERRUN, 0);

        drive(1, 0, 0, 0);
        send_bits(8'hA5, 1'b0);
        drive(0, 1, 1, 0);
        check("ovr_set", OVERRUN, 1);
        check("ovr_idle_load", LOAD, 0);
        check("ovr_idle_dout", DOUT, 8'hA5);
        drive(0, 0, 0, 0);
        check("ovr_sticky", OVERRUN, 1);
        drive(1, 0, 0, 0);
        send_bits(8'h3C, 1'b0);
        drive(0, 0, 1, 1);
        check("ovr_set_wins", OVERRUN, 1);
        drive(0, 0, 0, 1);
        check("ovr_clr", OVERRUN, 0);
        drive(0, 1, 1, 0);
        check("ovr_idle_noset", OVERRUN, 0);

        l0 = loads;
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        #3;
        N_RESET = 1'b1;
        #1;
        check("mid_rst_dout", DOUT, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_load", LOAD, 0);
        check("mid_rst_ovr", OVERRUN, 0);
        @(posedge CLK);
        #1;
        N_RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 0);
            check("post_rst_busy", BUSY, 0);
            check("post_rst_ovr", OVERRUN, 0);
        end
        check("mid_rst_noload", loads - l0, 0);
        drive(1, 0, 0, 0);
        send_bits(8'h5C, 1'b0);
        check("post_rst_dout", DOUT, 8'h5C);
        drive(0, 0, 0, 0);

        l0 = loads;
        drive(1, 0, 0, 0);
        send_bits(8'hFF, 1'b0);
        check("b2b_load1", LOAD, 1);
        check("b2b_dout1", DOUT, 8'hFF);
        drive(1, 0, 0, 0);
        check("b2b_busy", BUSY, 1);
        check("b2b_noload", LOAD, 0);
        check("b2b_hold", DOUT, 8'hFF);
        send_bits(8'h01, 1'b0);
        check("b2b_load2", LOAD, 1);
        check("b2b_dout2", DOUT, 8'h01);
        drive(0, 0, 0, 0);
        check("b2b_two_loads", loads - l0, 2);

        drive(0, 0, 0, 0);
        check("sb_drained", sb.size(), 0);
        check("sb_total_loads", loads, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
